axi_ram_responder: RTL and testbench
====================================

AXI_RAM_RESPONDER -- requirements
Module: axi_ram_responder

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 4, ID width.
REQ-002 SHALL have parameter AXI_ADDR_W, default 14, byte-address width; memory depth 2^(AXI_ADDR_W-2) words.
REQ-003 SHALL have parameter AXI_DATA_W, default 32, data width; only 32 is supported.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  AXI_ID_W/AXI_ADDR_W/8/3/2/1  write address.
REQ-007 s_axi_awready  out  1  write address accept.
REQ-008 s_axi_wdata/wstrb/wlast/wvalid  in  32/4/1/1  write data.
REQ-009 s_axi_wready  out  1  write data accept.
REQ-010 s_axi_bid/bresp/bvalid  out  AXI_ID_W/2/1  write response; s_axi_bready in 1.
REQ-011 s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  AXI_ID_W/AXI_ADDR_W/8/3/2/1  read address.
REQ-012 s_axi_arready  out  1  read address accept.
REQ-013 s_axi_rid/rdata/rresp/rlast/rvalid  out  AXI_ID_W/32/2/1/1  read data; s_axi_rready in 1.
REQ-014 Lock, cache, prot and qos inputs SHALL be accepted and ignored.

Function
REQ-015 FSM states SHALL be IDLE, WDATA, WRESP, RADDR, RDATA; exactly one transaction is in flight.
REQ-016 In IDLE, awready=1 when awvalid=1; otherwise arready=1 when arvalid=1. Write wins when both are valid on the same cycle.
REQ-017 An AW handshake SHALL latch id, word address awaddr[ADDR_W-1:2] and awlen, then go to WDATA.
REQ-018 In WDATA, wready=1; each W handshake SHALL write the bytes enabled by wstrb at the current word; the word address then increments.
REQ-019 WDATA SHALL end on beat awlen+1, then go to WRESP; the wlast value is not used to terminate.
REQ-020 bresp SHALL be 2'b10 (SLVERR) if wlast mismatches on any beat (wlast=1 early, or wlast=0 on the final beat); otherwise 2'b00.
REQ-021 In WRESP, bvalid=1 and bid=latched id, held until bready; then go to IDLE.
REQ-022 An AR handshake SHALL latch id, word address and arlen, then go to RADDR, which issues the memory read (1-cycle read latency).
REQ-023 In RDATA, rvalid=1 and rid=latched id; rresp=00; rlast=1 on beat arlen+1.
REQ-024 While rvalid=1 and rready=0, rdata/rlast SHALL be held stable.
REQ-025 Each R handshake SHALL advance to the next beat; rvalid may drop for at most one cycle between beats. After the last beat, go to IDLE.
REQ-026 Burst type SHALL be ignored and always treated as INCR; awsize/arsize SHALL be ignored (full word); address LSBs [1:0] SHALL be ignored.
REQ-027 The word address SHALL wrap modulo memory depth; no 4 KB boundary check.
REQ-028 awlen=0 / arlen=0 SHALL yield a single beat, with wlast/rlast expected/asserted on it.
REQ-029 Throughput: one W beat per cycle; first R beat at most 2 cycles after the AR handshake.

Reset
REQ-030 rst SHALL force IDLE and drive awready, wready, arready, bvalid, rvalid, rlast = 0, and bresp, rresp, bid, rid, rdata = 0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset mid-burst SHALL abandon the transaction with no response. Writes already performed SHALL persist.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-034 SHALL instantiate one sub-module iob_ram_sp_be: single-port, byte-enable, synchronous read.

Verification
REQ-035 Write then read, single beat: AW addr 0x10 len0, W 0xDEADBEEF strb F wlast1 -> bresp 00. AR 0x10 -> rdata 0xDEADBEEF, rlast 1.
REQ-036 Burst of 4 at 0x20 with bready/rready randomly low 50% -> read returns identical data; rlast only on beat 4; data stable under stall.
REQ-037 Byte strobes: write 0x11223344, then write 0xAABBCCDD with strb 0101 -> read returns 0x11BB33DD.
REQ-038 Simultaneous awvalid and arvalid in IDLE -> AW accepted first; AR accepted only after bvalid/bready.
REQ-039 wlast=1 on beat 2 of a len3 burst -> all 4 beats written; bresp=10.
REQ-040 Assert rst during beat 3 of an 8-beat read -> rvalid=0 immediately; next AR served normally; top-address wrap check: len1 burst at the last word reads word 0 second.

Source files
------------

// File: rtl/axi_ram_responder_pkg.sv
// Shared definitions for the AXI RAM responder: FSM state encoding and AXI response codes.
package axi_ram_responder_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWdata = 3'd1,
        StWresp = 3'd2,
        StRaddr = 3'd3,
        StRdata = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_ram_responder_if.sv
// AXI4 slave-side bus bundle for the RAM responder; master drives requests, slave responds.
interface axi_ram_responder_if #(
    parameter int unsigned AXI_ID_W   = 4,
    parameter int unsigned AXI_ADDR_W = 14,
    parameter int unsigned AXI_DATA_W = 32
);
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and one-cycle synchronous read.
module iob_ram_sp_be #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic [DATA_W/8-1:0] i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_d,
    output logic [DATA_W-1:0]   o_d
);
    logic [DATA_W-1:0] r_mem [0:2**ADDR_W-1];
    logic [DATA_W-1:0] r_dout;

    // Read port only updates on a non-writing access, so the output holds between reads.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we == '0) begin
                r_dout <= r_mem[i_addr];
            end
            for (int b = 0; b < int'(DATA_W / 8); b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_d[8*b +: 8];
                end
            end
        end
    end

    assign o_d = r_dout;

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a single-port RAM; serves one INCR burst (read or write) at a time.
module axi_ram_responder
    import axi_ram_responder_pkg::*;
#(
    parameter int unsigned AXI_ID_W   = 4,
    parameter int unsigned AXI_ADDR_W = 14,
    parameter int unsigned AXI_DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    axi_ram_responder_if.slave s_axi
);
    localparam int unsigned WORD_W = AXI_ADDR_W - 2;
    localparam int unsigned STRB_W = AXI_DATA_W / 8;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [AXI_ID_W-1:0]   r_id;
    logic [WORD_W-1:0]     r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic                  r_err;

    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_last_beat;
    logic                  w_ram_en;
    logic [STRB_W-1:0]     w_ram_we;
    logic [WORD_W-1:0]     w_ram_addr;
    logic [AXI_DATA_W-1:0] w_ram_q;
    logic                  w_unused;

    // Size, burst type, byte offset and the sideband qualifiers have no effect on this RAM.
    assign w_unused = ^{s_axi.awaddr[1:0], s_axi.awsize, s_axi.awburst, s_axi.awlock,
                        s_axi.awcache, s_axi.awprot, s_axi.awqos,
                        s_axi.araddr[1:0], s_axi.arsize, s_axi.arburst, s_axi.arlock,
                        s_axi.arcache, s_axi.arprot, s_axi.arqos};

    assign w_last_beat = (r_beat == r_len);

    always_comb begin
        w_state_nxt   = r_state;
        w_aw_hs       = 1'b0;
        w_ar_hs       = 1'b0;
        w_w_hs        = 1'b0;
        w_r_hs        = 1'b0;
        w_ram_en      = 1'b0;
        w_ram_we      = '0;
        w_ram_addr    = r_addr;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bid     = '0;
        s_axi.bresp   = RESP_OKAY;
        s_axi.rvalid  = 1'b0;
        s_axi.rid     = '0;
        s_axi.rdata   = '0;
        s_axi.rresp   = RESP_OKAY;
        s_axi.rlast   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (s_axi.awvalid) begin
                    s_axi.awready = 1'b1;
                    w_aw_hs       = 1'b1;
                    w_state_nxt   = StWdata;
                end else if (s_axi.arvalid) begin
                    s_axi.arready = 1'b1;
                    w_ar_hs       = 1'b1;
                    w_state_nxt   = StRaddr;
                end
            end
            StWdata: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid) begin
                    w_w_hs   = 1'b1;
                    w_ram_en = 1'b1;
                    w_ram_we = s_axi.wstrb;
                    // Burst length alone ends the data phase; wlast only feeds the error flag.
                    if (w_last_beat) begin
                        w_state_nxt = StWresp;
                    end
                end
            end
            StWresp: begin
                s_axi.bvalid = 1'b1;
                s_axi.bid    = r_id;
                s_axi.bresp  = r_err ? RESP_SLVERR : RESP_OKAY;
                if (s_axi.bready) begin
                    w_state_nxt = StIdle;
                end
            end
            StRaddr: begin
                w_ram_en    = 1'b1;
                w_state_nxt = StRdata;
            end
            StRdata: begin
                s_axi.rvalid = 1'b1;
                s_axi.rid    = r_id;
                s_axi.rdata  = w_ram_q;
                s_axi.rlast  = w_last_beat;
                if (s_axi.rready) begin
                    w_r_hs = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = StIdle;
                    end else begin
                        // Prefetch the next word now so beats stream without a bubble.
                        w_ram_en   = 1'b1;
                        w_ram_addr = r_addr + WORD_W'(1);
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_id   <= s_axi.awid;
                r_addr <= s_axi.awaddr[AXI_ADDR_W-1:2];
                r_len  <= s_axi.awlen;
                r_beat <= '0;
                r_err  <= 1'b0;
            end
            if (w_ar_hs) begin
                r_id   <= s_axi.arid;
                r_addr <= s_axi.araddr[AXI_ADDR_W-1:2];
                r_len  <= s_axi.arlen;
                r_beat <= '0;
            end
            if (w_w_hs) begin
                r_addr <= r_addr + WORD_W'(1);
                r_beat <= r_beat + 8'd1;
                if (s_axi.wlast != w_last_beat) begin
                    r_err <= 1'b1;
                end
            end
            if (w_r_hs) begin
                r_addr <= r_addr + WORD_W'(1);
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    iob_ram_sp_be #(
        .ADDR_W (WORD_W),
        .DATA_W (AXI_DATA_W)
    ) u_ram (
        .clk    (clk),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_d    (s_axi.wdata),
        .o_d    (w_ram_q)
    );

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed + randomized bench for axi_ram_responder against a word-array memory model.
module tb_axi_ram_responder;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_ram_responder_if #(.AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(32)) bus ();

    axi_ram_responder #(
        .AXI_ID_W   (ID_W),
        .AXI_ADDR_W (ADDR_W),
        .AXI_DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [DEPTH];
    logic [3:0]  known [DEPTH];
    logic [31:0] g_wdata [256];
    logic [3:0]  g_wstrb [256];
    bit mon_ar  = 1'b0;
    int ar_viol = 0;

    // Read address must stay blocked while a write transaction owns the responder.
    always @(negedge clk) if (mon_ar && bus.arready) ar_viol++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                model[a][8*b +: 8] = d[8*b +: 8];
                known[a][b] = 1'b1;
            end
        end
    endfunction

    task automatic idle_inputs();
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'd1;
        bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awqos = 0; bus.awvalid = 0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'd1;
        bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arqos = 0; bus.arvalid = 0;
        bus.rready = 0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [11:0] waddr, input int len);
        int cyc = 0;
        logic [1:0] lsb = 2'($urandom);
        bus.awid = id; bus.awaddr = {waddr, lsb}; bus.awlen = 8'(len);
        bus.awsize = 3'($urandom); bus.awburst = 2'($urandom); bus.awvalid = 1'b1;
        @(negedge clk);
        while (!bus.awready && cyc < 50) begin @(negedge clk); cyc++; end
        check("aw_timeout", 64'(cyc >= 50), 0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic wl);
        int cyc = 0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = wl; bus.wvalid = 1'b1;
        @(negedge clk);
        while (!bus.wready && cyc < 50) begin @(negedge clk); cyc++; end
        check("w_timeout", 64'(cyc >= 50), 0);
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    // wl_beat < 0: wlast on final beat; otherwise wlast only on beat wl_beat (may be beyond len).
    task automatic do_write(input logic [3:0] id, input logic [11:0] waddr, input int len,
                            input int wl_beat, input bit rand_b);
        bit exp_err = 0;
        bit done = 0;
        logic [1:0] bresp_o = 'x;
        logic [3:0] bid_o = 'x;
        send_aw(id, waddr, len);
        for (int i = 0; i <= len; i++) begin
            logic wl = (wl_beat < 0) ? (i == len) : (i == wl_beat);
            if (wl != (i == len)) exp_err = 1;
            send_w(g_wdata[i], g_wstrb[i], wl);
            model_write((int'(waddr) + i) % DEPTH, g_wdata[i], g_wstrb[i]);
        end
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            bus.bready = rand_b ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (bus.bvalid && bus.bready) begin
                done = 1; bresp_o = bus.bresp; bid_o = bus.bid;
            end
            @(posedge clk); #1;
        end
        bus.bready = 1'b0;
        check("b_timeout", 64'(done), 1);
        check("b_resp", bresp_o, exp_err ? 2'b10 : 2'b00);
        check("b_id", bid_o, id);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [11:0] waddr, input int len);
        int cyc = 0;
        logic [1:0] lsb = 2'($urandom);
        bus.arid = id; bus.araddr = {waddr, lsb}; bus.arlen = 8'(len);
        bus.arsize = 3'($urandom); bus.arburst = 2'($urandom); bus.arvalid = 1'b1;
        @(negedge clk);
        while (!bus.arready && cyc < 50) begin @(negedge clk); cyc++; end
        check("ar_timeout", 64'(cyc >= 50), 0);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [11:0] waddr, input int len,
                           input bit rand_r);
        int beat = 0;
        int lat = 0;
        bit first = 1;
        bit held = 0;
        logic [31:0] hd = '0;
        logic hl = 0;
        send_ar(id, waddr, len);
        for (int cyc = 0; cyc < 1000 && beat <= len; cyc++) begin
            bus.rready = rand_r ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (first) lat++;
            if (held && !bus.rvalid) check("r_stall_valid", 0, 1);
            if (bus.rvalid) begin
                int a = (int'(waddr) + beat) % DEPTH;
                if (first) begin check("r_first_latency", 64'(lat <= 2), 1); first = 0; end
                if (held) begin
                    check("r_stall_data", bus.rdata, hd);
                    check("r_stall_last", bus.rlast, hl);
                end
                if (bus.rready) begin
                    check("r_data", bus.rdata & bmask(known[a]), model[a] & bmask(known[a]));
                    check("r_last", bus.rlast, beat == len);
                    check("r_id", bus.rid, id);
                    check("r_resp", bus.rresp, 2'b00);
                    beat++;
                    held = 0;
                end else begin
                    held = 1; hd = bus.rdata; hl = bus.rlast;
                end
            end else begin
                held = 0;
            end
            @(posedge clk); #1;
        end
        bus.rready = 1'b0;
        check("r_beats", beat, len + 1);
        @(negedge clk);
        check("r_idle_after", bus.rvalid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin model[i] = '0; known[i] = '0; end
        idle_inputs();
        rst = 1'b1;
        #12;
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_resp_ids", {bus.bresp, bus.rresp, bus.bid, bus.rid}, 0);
        check("rst_rdata", bus.rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat write then read
        g_wdata[0] = 32'hDEADBEEF; g_wstrb[0] = 4'hF;
        do_write(4'd3, 12'h004, 0, -1, 0);
        do_read(4'd5, 12'h004, 0, 0);

        // Burst of 4 at byte 0x20 with random back-pressure
        for (int i = 0; i < 4; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
        do_write(4'd7, 12'h008, 3, -1, 1);
        do_read(4'd9, 12'h008, 3, 1);

        // Byte strobes
        g_wdata[0] = 32'h11223344; g_wstrb[0] = 4'hF;
        do_write(4'd1, 12'h010, 0, -1, 0);
        g_wdata[0] = 32'hAABBCCDD; g_wstrb[0] = 4'b0101;
        do_write(4'd1, 12'h010, 0, -1, 0);
        check("strb_model", model[16], 32'h11BB33DD);
        do_read(4'd2, 12'h010, 0, 0);

        // Early wlast on beat 2 of a 4-beat burst, and a burst with wlast never asserted
        for (int i = 0; i < 4; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
        do_write(4'd4, 12'h020, 3, 1, 0);
        do_read(4'd4, 12'h020, 3, 0);
        for (int i = 0; i < 3; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
        do_write(4'd6, 12'h030, 2, 99, 0);

        // Simultaneous AW and AR: write must win, AR waits for B handshake
        bus.arid = 4'hA; bus.araddr = {12'h040, 2'b00}; bus.arlen = 8'd0; bus.arvalid = 1'b1;
        mon_ar = 1'b1;
        g_wdata[0] = $urandom; g_wstrb[0] = 4'hF;
        do_write(4'hB, 12'h040, 0, -1, 1);
        mon_ar = 1'b0;
        check("ar_blocked_during_write", ar_viol, 0);
        do_read(4'hA, 12'h040, 0, 0);

        // Reset during beat 3 of an 8-beat read
        for (int i = 0; i < 8; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
        do_write(4'd3, 12'h100, 7, -1, 0);
        send_ar(4'd3, 12'h100, 7);
        begin
            int beat = 0;
            bit hit = 0;
            for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
                bus.rready = 1'b1;
                @(negedge clk);
                if (bus.rvalid) begin
                    if (beat == 2) begin
                        rst = 1'b1; #1;
                        hit = 1;
                        check("rst_mid_rvalid", bus.rvalid, 0);
                        check("rst_mid_rdata", {bus.rdata, bus.rlast}, 0);
                    end
                    beat++;
                end
                if (!hit) begin @(posedge clk); #1; end
            end
            check("rst_mid_reached", 64'(hit), 1);
        end
        bus.rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read(4'd8, 12'h100, 7, 1);

        // Reset mid-write: beats already written persist
        send_aw(4'd2, 12'h200, 5);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] d = $urandom;
            send_w(d, 4'hF, 1'b0);
            model_write(16'h200 + i, d, 4'hF);
        end
        rst = 1'b1; #1;
        check("rst_mid_wready", bus.wready, 0);
        check("rst_mid_bvalid", bus.bvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read(4'd2, 12'h200, 1, 0);

        // Top-address wrap
        g_wdata[0] = $urandom; g_wdata[1] = $urandom; g_wstrb[0] = 4'hF; g_wstrb[1] = 4'hF;
        do_write(4'd5, 12'hFFF, 1, -1, 0);
        check("wrap_word0_model", model[0], g_wdata[1]);
        do_read(4'd5, 12'hFFF, 1, 0);
        do_read(4'd6, 12'h000, 0, 0);

        // Randomized bursts
        for (int t = 0; t < 16; t++) begin
            logic [11:0] wa = 12'($urandom);
            int len = $urandom_range(0, 7);
            logic [3:0] id = 4'($urandom);
            for (int i = 0; i <= len; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'($urandom); end
            do_write(id, wa, len, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, 1);
            do_read(~id, wa, len, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
